// File: rtl/axi_line_bridge_if.sv
// Cache-line request port plus the AXI4 master channels of axi_line_bridge.
// "master" is the bridge side; "slave" is the requester plus the interconnect.
interface axi_line_bridge_if #(
   parameter int ADDR_W = 64
);
   logic              rw_valid_i;
   logic              rw_req_i;
   logic [ADDR_W-1:0] rw_addr_i;
   logic [127:0]      rw_wdata_i;
   logic              rw_ready_o;
   logic [127:0]      data_read_o;
   logic [1:0]        rw_resp_o;

   logic              axi_ar_valid_o;
   logic              axi_ar_ready_i;
   logic [ADDR_W-1:0] axi_ar_addr_o;
   logic [7:0]        axi_ar_len_o;
   logic [2:0]        axi_ar_size_o;
   logic [1:0]        axi_ar_burst_o;

   logic              axi_r_valid_i;
   logic              axi_r_ready_o;
   logic [63:0]       axi_r_data_i;
   logic [1:0]        axi_r_resp_i;
   logic              axi_r_last_i;

   logic              axi_aw_valid_o;
   logic              axi_aw_ready_i;
   logic [ADDR_W-1:0] axi_aw_addr_o;
   logic [7:0]        axi_aw_len_o;
   logic [2:0]        axi_aw_size_o;
   logic [1:0]        axi_aw_burst_o;

   logic              axi_w_valid_o;
   logic              axi_w_ready_i;
   logic [63:0]       axi_w_data_o;
   logic [7:0]        axi_w_strb_o;
   logic              axi_w_last_o;

   logic              axi_b_valid_i;
   logic              axi_b_ready_o;
   logic [1:0]        axi_b_resp_i;

   modport master (
      input  rw_valid_i, rw_req_i, rw_addr_i, rw_wdata_i,
      output rw_ready_o, data_read_o, rw_resp_o,
      output axi_ar_valid_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
      input  axi_ar_ready_i,
      input  axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
      output axi_r_ready_o,
      output axi_aw_valid_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
      input  axi_aw_ready_i,
      output axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
      input  axi_w_ready_i,
      input  axi_b_valid_i, axi_b_resp_i,
      output axi_b_ready_o
   );

   modport slave (
      output rw_valid_i, rw_req_i, rw_addr_i, rw_wdata_i,
      input  rw_ready_o, data_read_o, rw_resp_o,
      input  axi_ar_valid_o, axi_ar_addr_o, axi_ar_len_o, axi_ar_size_o, axi_ar_burst_o,
      output axi_ar_ready_i,
      output axi_r_valid_i, axi_r_data_i, axi_r_resp_i, axi_r_last_i,
      input  axi_r_ready_o,
      input  axi_aw_valid_o, axi_aw_addr_o, axi_aw_len_o, axi_aw_size_o, axi_aw_burst_o,
      output axi_aw_ready_i,
      input  axi_w_valid_o, axi_w_data_o, axi_w_strb_o, axi_w_last_o,
      output axi_w_ready_i,
      output axi_b_valid_i, axi_b_resp_i,
      input  axi_b_ready_o
   );
endinterface

// File: rtl/axi_line_bridge.sv
// Turns one 128-bit cache line request at a time into a 2-beat AXI4 burst on a
// 64-bit bus: INCR read for refills, write burst plus B response for write-backs.
module axi_line_bridge #(
   parameter int ADDR_W     = 64,
   parameter int LINE_BYTES = 16
) (
   input logic               clock,
   input logic               reset,
   axi_line_bridge_if.master bus
);

   typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [127:0]      wdata_q;
   logic [127:0]      line_q, line_upd;
   logic [127:0]      data_read_q;
   logic              cnt_q;
   logic [1:0]        w_cnt_q;
   logic              aw_done_q;
   logic [1:0]        resp_q, resp_upd;
   logic [1:0]        rw_resp_q;

   logic ar_valid, r_ready, aw_valid, w_valid, b_ready, rw_ready;
   logic accept, r_hs, aw_hs, w_hs, r_exit, proto_err;

   assign accept = (state_q == IDLE) & bus.rw_valid_i;
   assign r_hs   = r_ready & bus.axi_r_valid_i;
   assign aw_hs  = aw_valid & bus.axi_aw_ready_i;
   assign w_hs   = w_valid & bus.axi_w_ready_i;
   // A burst ends on r_last or on the second beat, whichever comes first.
   assign r_exit    = r_hs & (bus.axi_r_last_i | cnt_q);
   assign proto_err = cnt_q ? ~bus.axi_r_last_i : bus.axi_r_last_i;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      line_upd = line_q;
      if (cnt_q) line_upd[127:64] = bus.axi_r_data_i;
      else       line_upd[63:0]   = bus.axi_r_data_i;
      resp_upd = (bus.axi_r_resp_i > resp_q) ? bus.axi_r_resp_i : resp_q;
   end

   always_comb begin
      state_d  = state_q;
      ar_valid = 1'b0;
      r_ready  = 1'b0;
      aw_valid = 1'b0;
      w_valid  = 1'b0;
      b_ready  = 1'b0;
      rw_ready = 1'b0;
      unique case (state_q)
         IDLE: if (bus.rw_valid_i) state_d = bus.rw_req_i ? AW_W : AR;
         AR: begin
            ar_valid = 1'b1;
            if (bus.axi_ar_ready_i) state_d = R;
         end
         R: begin
            r_ready = 1'b1;
            if (r_exit) state_d = RESP;
         end
         AW_W: begin
            aw_valid = ~aw_done_q;
            w_valid  = ~w_cnt_q[1];
            if ((aw_done_q | aw_hs) &&
                (w_cnt_q[1] | (w_cnt_q[0] & w_hs)))
               state_d = B;
         end
         B: begin
            b_ready = 1'b1;
            if (bus.axi_b_valid_i) state_d = RESP;
         end
         RESP: begin
            rw_ready = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments keep every register update in step at the clock edge.
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 1'b0;
         w_cnt_q     <= 2'd0;
         aw_done_q   <= 1'b0;
         resp_q      <= 2'd0;
         data_read_q <= '0;
         rw_resp_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q     <= 1'b0;
            w_cnt_q   <= 2'd0;
            aw_done_q <= 1'b0;
            resp_q    <= 2'd0;
         end
         if (r_hs) begin
            cnt_q  <= cnt_q + 1'b1;
            resp_q <= resp_upd;
         end
         // Results are published on entry to RESP and held until the next one.
         if (r_exit) begin
            data_read_q <= line_upd;
            rw_resp_q   <= proto_err ? 2'b10 : resp_upd;
         end
         if (aw_hs) aw_done_q <= 1'b1;
         if (w_hs)  w_cnt_q   <= w_cnt_q + 2'd1;
         if (b_ready && bus.axi_b_valid_i) begin
            data_read_q <= '0;
            rw_resp_q   <= bus.axi_b_resp_i;
         end
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: pure datapath registers are always loaded before use, so they carry no reset.
      if (accept) begin
         addr_q  <= bus.rw_addr_i & ~ADDR_W'(LINE_BYTES - 1);
         wdata_q <= bus.rw_wdata_i;
         line_q  <= '0;
      end else if (r_hs) begin
         line_q <= line_upd;
      end
   end

   assign bus.axi_ar_valid_o = ar_valid;
   assign bus.axi_ar_addr_o  = addr_q;
   assign bus.axi_ar_len_o   = 8'd1;
   assign bus.axi_ar_size_o  = 3'd3;
   assign bus.axi_ar_burst_o = 2'b01;
   assign bus.axi_r_ready_o  = r_ready;

   assign bus.axi_aw_valid_o = aw_valid;
   assign bus.axi_aw_addr_o  = addr_q;
   assign bus.axi_aw_len_o   = 8'd1;
   assign bus.axi_aw_size_o  = 3'd3;
   assign bus.axi_aw_burst_o = 2'b01;
   assign bus.axi_w_valid_o  = w_valid;
   assign bus.axi_w_data_o   = w_cnt_q[0] ? wdata_q[127:64] : wdata_q[63:0];
   assign bus.axi_w_strb_o   = 8'hFF;
   assign bus.axi_w_last_o   = w_cnt_q[0];
   assign bus.axi_b_ready_o  = b_ready;

   assign bus.rw_ready_o  = rw_ready;
   assign bus.data_read_o = data_read_q;
   assign bus.rw_resp_o   = rw_resp_q;

endmodule

// File: tb/tb_axi_line_bridge.sv
// Self-checking bench for axi_line_bridge: the bench plays requester and AXI slave,
// and expected lines/responses come from a burst-level reference model.
module tb_axi_line_bridge;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   vectors     = 0;
   int   miscompares = 0;

   axi_line_bridge_if #(.ADDR_W(64)) bus ();

   axi_line_bridge #(.ADDR_W(64), .LINE_BYTES(16)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Reference: line is the received beats in order (missing beats read 0), resp is
   // the worst beat response, overridden to SLVERR on a misplaced or missing r_last.
   task automatic ref_read(input int n, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [1:0] r0, input logic [1:0] r1,
                           input bit l0, input bit l1,
                           output logic [127:0] line, output logic [1:0] resp);
      logic [63:0] beats[$];
      logic [1:0]  resps[$];
      beats = {d0};
      resps = {r0};
      if (n == 2) begin
         beats.push_back(d1);
         resps.push_back(r1);
      end
      line = '0;
      resp = 2'd0;
      foreach (beats[i]) begin
         line = line | (128'(beats[i]) << (64 * i));
         if (resps[i] > resp) resp = resps[i];
      end
      if (l0 || (n == 2 && !l1)) resp = 2'b10;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ar_valid"}, 128'(bus.axi_ar_valid_o), 128'(0));
      check({tag, "_r_ready"},  128'(bus.axi_r_ready_o),  128'(0));
      check({tag, "_aw_valid"}, 128'(bus.axi_aw_valid_o), 128'(0));
      check({tag, "_w_valid"},  128'(bus.axi_w_valid_o),  128'(0));
      check({tag, "_b_ready"},  128'(bus.axi_b_ready_o),  128'(0));
      check({tag, "_rw_ready"}, 128'(bus.rw_ready_o),     128'(0));
   endtask

   // Called at a negedge. exp_lat is the number of clock edges from valid to the
   // visible ready pulse (4 means ready shows in the fifth cycle), -1 to skip.
   task automatic do_read(input logic [63:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input logic [1:0] r0, input logic [1:0] r1, input bit l0, input bit l1,
                          input int ar_dly, input int r_gap, input int exp_lat, input bit abort);
      int          n = l0 ? 1 : 2;
      int          sent = 0, ar_hs = 0, ar_wait = 0, gap = r_gap, cyc = 0;
      bit          ar_started = 0, ar_done = 0, done = 0;
      logic [63:0] exp_addr = addr & ~64'hF;
      logic [127:0] exp_line;
      logic [1:0]   exp_resp;
      ref_read(n, d0, d1, r0, r1, l0, l1, exp_line, exp_resp);
      bus.rw_valid_i = 1'b1;
      bus.rw_req_i   = 1'b0;
      bus.rw_addr_i  = addr;
      bus.rw_wdata_i = {rnd64(), rnd64()};
      while (!done && cyc < 200) begin
         @(negedge clock);
         cyc++;
         bus.rw_addr_i  = rnd64();
         bus.rw_wdata_i = {rnd64(), rnd64()};
         bus.rw_req_i   = 1'($urandom);
         if (bus.axi_ar_ready_i) ar_done = 1;
         if (abort && sent == 1) begin
            reset = 1'b1;
            bus.rw_valid_i = 1'b0;
            bus.axi_r_valid_i = 1'b0;
            bus.axi_ar_ready_i = 1'b0;
            @(negedge clock);
            check_quiet("abort");
            check("abort_data", bus.data_read_o, 128'(0));
            check("abort_resp", 128'(bus.rw_resp_o), 128'(0));
            reset = 1'b0;
            return;
         end
         if (bus.rw_ready_o) begin
            done = 1;
            bus.rw_valid_i = 1'b0;
            bus.axi_r_valid_i = 1'b0;
            bus.axi_ar_ready_i = 1'b0;
            check("rd_data", bus.data_read_o, exp_line);
            check("rd_resp", 128'(bus.rw_resp_o), 128'(exp_resp));
            check("rd_ar_count", 128'(ar_hs), 128'(1));
            check("rd_beats", 128'(sent), 128'(n));
            check("rd_r_ready_in_resp", 128'(bus.axi_r_ready_o), 128'(0));
            if (exp_lat >= 0) check("rd_latency", 128'(cyc), 128'(exp_lat));
         end else begin
            if (ar_started && !ar_done) check("ar_hold", 128'(bus.axi_ar_valid_o), 128'(1));
            if (bus.axi_ar_valid_o) begin
               ar_started = 1;
               check("ar_addr",  128'(bus.axi_ar_addr_o),  128'(exp_addr));
               check("ar_len",   128'(bus.axi_ar_len_o),   128'(1));
               check("ar_size",  128'(bus.axi_ar_size_o),  128'(3));
               check("ar_burst", 128'(bus.axi_ar_burst_o), 128'(1));
               if (ar_wait >= ar_dly) begin
                  bus.axi_ar_ready_i = 1'b1;
                  ar_hs++;
               end else begin
                  bus.axi_ar_ready_i = 1'b0;
                  ar_wait++;
               end
            end else begin
               bus.axi_ar_ready_i = 1'b0;
            end
            if (ar_done && sent < n && gap >= r_gap) begin
               bus.axi_r_valid_i = 1'b1;
               bus.axi_r_data_i  = (sent == 0) ? d0 : d1;
               bus.axi_r_resp_i  = (sent == 0) ? r0 : r1;
               bus.axi_r_last_i  = (sent == 0) ? l0 : l1;
               if (bus.axi_r_ready_o) begin
                  sent++;
                  gap = 0;
               end
            end else begin
               bus.axi_r_valid_i = 1'b0;
               bus.axi_r_data_i  = rnd64();
               if (ar_done && sent > 0) gap++;
            end
         end
      end
      if (!done) begin
         check("rd_timeout", 128'(bus.rw_ready_o), 128'(1));
         return;
      end
      @(negedge clock);
      check("rd_pulse_end", 128'(bus.rw_ready_o), 128'(0));
      check("rd_data_hold", bus.data_read_o, exp_line);
      check("rd_no_dup_ar", 128'(bus.axi_ar_valid_o), 128'(0));
   endtask

   task automatic do_write(input logic [63:0] addr, input logic [127:0] wdata, input logic [1:0] bresp,
                           input int aw_dly, input int w_stall, input int b_dly, input int exp_lat);
      int          cyc = 0, aw_hs = 0, aw_wait = 0, wbeats = 0, w_wait = 0, b_wait = 0;
      bit          aw_done = 0, w_done, b_hs = 0, done = 0;
      logic [63:0] exp_addr = addr & ~64'hF;
      logic [63:0] exp_beat;
      bus.rw_valid_i = 1'b1;
      bus.rw_req_i   = 1'b1;
      bus.rw_addr_i  = addr;
      bus.rw_wdata_i = wdata;
      while (!done && cyc < 200) begin
         @(negedge clock);
         cyc++;
         bus.rw_addr_i  = rnd64();
         bus.rw_wdata_i = {rnd64(), rnd64()};
         bus.rw_req_i   = 1'($urandom);
         if (bus.axi_aw_ready_i) aw_done = 1;
         w_done = (wbeats == 2);
         if (b_hs) bus.axi_b_valid_i = 1'b0;
         if (bus.rw_ready_o) begin
            done = 1;
            bus.rw_valid_i = 1'b0;
            bus.axi_aw_ready_i = 1'b0;
            bus.axi_w_ready_i  = 1'b0;
            bus.axi_b_valid_i  = 1'b0;
            check("wr_data_zero", bus.data_read_o, 128'(0));
            check("wr_resp", 128'(bus.rw_resp_o), 128'(bresp));
            check("wr_aw_count", 128'(aw_hs), 128'(1));
            check("wr_beats", 128'(wbeats), 128'(2));
            if (exp_lat >= 0) check("wr_latency", 128'(cyc), 128'(exp_lat));
         end else begin
            if (bus.axi_aw_valid_o) begin
               check("aw_addr",  128'(bus.axi_aw_addr_o),  128'(exp_addr));
               check("aw_len",   128'(bus.axi_aw_len_o),   128'(1));
               check("aw_size",  128'(bus.axi_aw_size_o),  128'(3));
               check("aw_burst", 128'(bus.axi_aw_burst_o), 128'(1));
               if (aw_wait >= aw_dly) begin
                  bus.axi_aw_ready_i = 1'b1;
                  aw_hs++;
               end else begin
                  bus.axi_aw_ready_i = 1'b0;
                  aw_wait++;
               end
            end else begin
               bus.axi_aw_ready_i = 1'b0;
            end
            if (bus.axi_w_valid_o) begin
               check("w_extra", 128'(wbeats < 2), 128'(1));
               exp_beat = (wbeats == 0) ? wdata[63:0] : wdata[127:64];
               check("w_data", 128'(bus.axi_w_data_o), 128'(exp_beat));
               check("w_strb", 128'(bus.axi_w_strb_o), 128'(8'hFF));
               check("w_last", 128'(bus.axi_w_last_o), 128'(wbeats == 1));
               if (w_wait >= w_stall) begin
                  bus.axi_w_ready_i = 1'b1;
                  wbeats++;
                  w_wait = 0;
               end else begin
                  bus.axi_w_ready_i = 1'b0;
                  w_wait++;
               end
            end else begin
               bus.axi_w_ready_i = 1'b0;
            end
            if (aw_done && w_done && !b_hs) begin
               if (b_wait >= b_dly) begin
                  bus.axi_b_valid_i = 1'b1;
                  bus.axi_b_resp_i  = bresp;
                  if (bus.axi_b_ready_o) b_hs = 1;
               end else begin
                  b_wait++;
               end
            end
         end
      end
      if (!done) begin
         check("wr_timeout", 128'(bus.rw_ready_o), 128'(1));
         return;
      end
      @(negedge clock);
      check("wr_pulse_end", 128'(bus.rw_ready_o), 128'(0));
      check("wr_no_dup_aw", 128'(bus.axi_aw_valid_o), 128'(0));
      check("wr_no_dup_w",  128'(bus.axi_w_valid_o),  128'(0));
   endtask

   initial begin
      logic [63:0] d0, d1;
      bus.rw_valid_i = 1'b0;
      bus.rw_req_i = 1'b0;
      bus.rw_addr_i = '0;
      bus.rw_wdata_i = '0;
      bus.axi_ar_ready_i = 1'b0;
      bus.axi_r_valid_i = 1'b0;
      bus.axi_r_data_i = '0;
      bus.axi_r_resp_i = 2'd0;
      bus.axi_r_last_i = 1'b0;
      bus.axi_aw_ready_i = 1'b0;
      bus.axi_w_ready_i = 1'b0;
      bus.axi_b_valid_i = 1'b0;
      bus.axi_b_resp_i = 2'd0;
      repeat (3) @(negedge clock);
      check_quiet("reset");
      check("reset_data", bus.data_read_o, 128'(0));
      check("reset_resp", 128'(bus.rw_resp_o), 128'(0));
      reset = 1'b0;
      @(negedge clock);

      // Zero-wait refill with the reference address and beat patterns.
      do_read(64'h8000_001C, {4{16'h1111}}, {4{16'h2222}}, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 4, 1'b0);
      // Back-pressure on AR and gaps between R beats.
      do_read(rnd64(), {4{16'h1111}}, {4{16'h2222}}, 2'd0, 2'd0, 1'b0, 1'b1, 3, 2, -1, 1'b0);
      // Write-back with AW accepted only after both W beats, then a zero-wait one.
      do_write(rnd64(), {{4{16'hAAAA}}, {4{16'h5555}}}, 2'd0, 4, 0, 0, -1);
      do_write(rnd64(), {rnd64(), rnd64()}, 2'd0, 0, 0, 0, 4);
      // Error responses: SLVERR on beat 1, then r_last on beat 0.
      do_read(rnd64(), rnd64(), rnd64(), 2'd0, 2'b10, 1'b0, 1'b1, 0, 0, -1, 1'b0);
      do_read(rnd64(), rnd64(), rnd64(), 2'd0, 2'd0, 1'b1, 1'b1, 0, 0, -1, 1'b0);
      // Reset after the first read beat, then a fresh read.
      do_read(rnd64(), rnd64(), rnd64(), 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, -1, 1'b1);
      d0 = rnd64();
      d1 = rnd64();
      do_read(rnd64(), d0, d1, 2'd0, 2'd0, 1'b0, 1'b1, 0, 0, 4, 1'b0);

      // Back-to-back random mix; every request starts one cycle after the prior ready.
      for (int i = 0; i < 24; i++) begin
         if ($urandom_range(0, 1) == 0)
            do_read(rnd64(), rnd64(), rnd64(), 2'($urandom), 2'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                    $urandom_range(0, 3), $urandom_range(0, 2), -1, 1'b0);
         else
            do_write(rnd64(), {rnd64(), rnd64()}, 2'($urandom),
                     $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 2), -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/axi_line_bridge.md
Name: axi_line_bridge

Overview:
- Memory-side responder for cache line requests (rw_valid/rw_req/rw_addr → rw_ready + 128-bit line).
- Converts each accepted request into an AXI4 master transaction on a 64-bit bus: 2-beat INCR read burst for refills, 2-beat write burst for write-backs.
- Sits between the cache and the SoC AXI interconnect. One outstanding transaction at a time.

Parameters:
- ADDR_W, 64, request and AXI address width.
- LINE_BYTES, 16, line size; requests are aligned to this (bits [3:0] cleared).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rw_valid_i  in  1  request valid, held by requester until rw_ready_o.
- rw_req_i  in  1  request type: 0=read line, 1=write line.
- rw_addr_i  in  64  line address; low 4 bits ignored.
- rw_wdata_i  in  128  write line; [63:0] is beat 0.
- rw_ready_o  out  1  one-cycle completion pulse.
- data_read_o  out  128  read line, valid with rw_ready_o.
- rw_resp_o  out  2  AXI response of the transaction, valid with rw_ready_o.
- axi_ar_valid_o / axi_ar_ready_i  out/in  1  read address handshake.
- axi_ar_addr_o  out  64; axi_ar_len_o  out  8; axi_ar_size_o  out  3; axi_ar_burst_o  out  2.
- axi_r_valid_i / axi_r_ready_o  in/out  1; axi_r_data_i  in  64; axi_r_resp_i  in  2; axi_r_last_i  in  1.
- axi_aw_valid_o / axi_aw_ready_i  out/in  1; axi_aw_addr_o  out  64; axi_aw_len_o  out  8; axi_aw_size_o  out  3; axi_aw_burst_o  out  2.
- axi_w_valid_o / axi_w_ready_i  out/in  1; axi_w_data_o  out  64; axi_w_strb_o  out  8; axi_w_last_o  out  1.
- axi_b_valid_i / axi_b_ready_o  in/out  1; axi_b_resp_i  in  2.

Behaviour:
- Reset (synchronous): state=IDLE. All *_valid_o, *_ready_o and rw_ready_o are 0. data_read_o and rw_resp_o are 0. Beat counter is 0.
- Reset mid-transaction aborts immediately to IDLE. This is acceptable only together with an interconnect reset.
- Constant fields: len=1 (2 beats), size=3 (8 bytes), burst=2'b01 INCR, w_strb=8'hFF.
- IDLE: if rw_valid_i=1, latch addr & ~0xF, rw_req_i and rw_wdata_i. Go to AR when rw_req_i=0, else AW_W. Acceptance costs one cycle.
- AR: ar_valid=1, ar_addr=latched addr. On ar_ready, go to R.
- R: r_ready=1.
  - Each r_valid&r_ready beat writes r_data into line[64*cnt +: 64] and increments cnt.
  - rresp accumulates as the maximum over beats.
  - Exit to RESP on the beat with r_last=1, or after beat 1.
  - Protocol errors force resp=2'b10: r_last on beat 0, or no r_last on beat 1. Unwritten upper half reads 0.
- AW_W: aw_valid and w_valid are asserted concurrently. aw_valid drops after its own handshake.
  - W beat 0 = wdata[63:0], last=0; beat 1 = wdata[127:64], last=1. Data is held stable while stalled.
  - When the AW handshake and both W beats are done (any order or same cycle), go to B.
- B: b_ready=1. On b_valid, capture bresp and go to RESP.
- RESP: rw_ready_o=1 for exactly one cycle. data_read_o is the assembled line for reads and 0 for writes. rw_resp_o = captured resp. Next state is IDLE.
  - rw_valid_i is not sampled in RESP. The requester drops it in response to ready, so there is no double accept.
- data_read_o and rw_resp_o hold their values until the next RESP.
- Latency (zero-wait slave): read = IDLE + AR + 2 R + RESP = 5 cycles from valid to ready. Write = IDLE + 2 AW_W + B + RESP = 5 cycles.
- Latched request fields are immune to rw_* input changes after acceptance.

Test Plan:
- Read, zero-wait slave: rw_addr_i=0x8000_001C, rw_req_i=0 → ar_addr=0x8000_0010, len=1, size=3, burst=1. Beats 0x1111…/0x2222… → data_read_o=0x2222…_1111…, rw_resp_o=0, rw_ready_o 1 cycle, 5 cycles after valid.
- Read with back-pressure: ar_ready delayed 3 cycles, 2 idle cycles between r beats → same data; ar_valid stays high and ar_addr stays stable while stalled; no extra beats consumed.
- Write: wdata=0xAAAA…_5555…, aw_ready delayed until after both W beats → w beats 0x5555… then 0xAAAA… (last=1), strb=FF; b_resp=0 → one rw_ready_o pulse, data_read_o=0.
- Errors: rresp=2'b10 on beat 1 → rw_resp_o=2; separate run with r_last on beat 0 → rw_resp_o=2, data_read_o[127:64]=0.
- Reset mid-R after beat 0 → next cycle all valids/readies are 0 and state is IDLE. A new read then completes normally with a fresh 2-beat count.
- Back-to-back: requester deasserts on ready and reasserts 1 cycle later → exactly one AR per request; no duplicate transaction issued during RESP.
